twiddle_gen_loader: RTL and testbench

- Run-time generator of FFT/IFFT twiddle factors W_N^k = exp(-j·2πk/N), for k = 0..N/2-1.
- Writes each factor into a twiddle RAM through a simple write port.
- Replaces the file-loaded twiddle table: after reset, the OFDM core pulses start, waits for done, then reads the RAM as before.
- Uses a single iterative CORDIC datapath (one micro-rotation per clock), sequenced by an FSM.

---
 rtl/twiddle_gen_loader.sv | 237 +++++++++++++++++++++++
 tb/tb_twiddle_gen_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_gen_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : twiddle_gen_loader                                            |
// | Purpose  : Run-time generator of FFT twiddle factors W_N^k, k=0..N/2-1,  |
// |            using one iterative CORDIC (one micro-rotation per clock)     |
// |            and writing each {real, imag} entry into a twiddle RAM.       |
// | Options  : TWIDDLE_GEN_CONJ_EN - emit conjugate (IFFT) twiddles.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module twiddle_gen_loader #(
    parameter int OFDM_WIDTH = 16,
    parameter int DATA_WIDTH = 12,
    parameter int ITER       = 14,
    parameter int ANGLE_W    = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            wr_en,
    output logic [$clog2(OFDM_WIDTH)-2:0]   wr_addr,
    output logic [2*DATA_WIDTH-1:0]         wr_data
);

    localparam int c_AW  = $clog2(OFDM_WIDTH);
    localparam int c_KW  = c_AW - 1;
    // two fractional guard bits plus one bit of headroom above the amplitude
    localparam int c_XW  = DATA_WIDTH + 3;
    localparam int c_IW  = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int c_AMP = (2 ** (DATA_WIDTH - 1)) - 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_ROTATE = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    // Gain-compensated start amplitude, in guard units (x4).
    function automatic int f_ka4();
        real g;
        real t;
        g = 1.0;
        t = 1.0;
        for (int i = 0; i < ITER; i++) begin
            g = g / $sqrt(1.0 + t * t);
            t = t / 2.0;
        end
        return $rtoi(g * 4.0 * $itor(c_AMP) + 0.5);
    endfunction

    // atan(2^-i) in angle units where 2^ANGLE_W is a full turn.
    function automatic int f_atan(input int i);
        real t;
        real scale;
        t = 1.0;
        for (int j = 0; j < i; j++) t = t / 2.0;
        scale = 1.0;
        for (int j = 0; j < ANGLE_W; j++) scale = scale * 2.0;
        return $rtoi($atan(t) * scale / 6.283185307179586 + 0.5);
    endfunction

    localparam int                       c_KA4     = f_ka4();
    localparam logic signed [c_XW-1:0]   c_KA4X    = c_XW'(c_KA4);
    localparam logic signed [c_XW-1:0]   c_A4X     = c_XW'(4 * c_AMP);
    localparam logic signed [c_XW-1:0]   c_HALF    = c_XW'(2);
    localparam logic signed [c_XW-1:0]   c_AMPX    = c_XW'(c_AMP);
    localparam logic signed [c_XW-1:0]   c_NEGX    = c_XW'(-c_AMP);
    localparam logic [DATA_WIDTH-1:0]    c_POS     = DATA_WIDTH'(c_AMP);
    localparam logic [DATA_WIDTH-1:0]    c_NEG     = DATA_WIDTH'(-c_AMP);
    localparam logic [ANGLE_W-1:0]       c_QUARTER = ANGLE_W'(1) << (ANGLE_W - 2);

    // Round half-up from guard units to output LSBs.
    function automatic logic signed [c_XW-1:0] f_round(input logic signed [c_XW-1:0] v);
        return (v + c_HALF) >>> 2;
    endfunction

    // Clamp a rounded component to the symmetric range +/-A.
    function automatic logic [DATA_WIDTH-1:0] f_sat(input logic signed [c_XW-1:0] v);
        if (v > c_AMPX)      return c_POS;
        else if (v < c_NEGX) return c_NEG;
        else                 return v[DATA_WIDTH-1:0];
    endfunction

    logic [ANGLE_W-1:0] w_atan [ITER];

    for (genvar gi = 0; gi < ITER; gi++) begin : g_atan
        localparam int c_ATAN = f_atan(gi);
        assign w_atan[gi] = ANGLE_W'(c_ATAN);
    end

    logic [2:0]                r_state, w_state_nxt;
    logic [c_KW-1:0]           r_k;
    logic [c_IW-1:0]           r_iter;
    logic signed [c_XW-1:0]    r_x, r_y;
    logic signed [ANGLE_W-1:0] r_z;
    logic                      r_hold;

    logic                      w_accept, w_last_k, w_last_iter, w_axis;
    logic [ANGLE_W-1:0]        w_k_ext, w_theta;
    logic signed [ANGLE_W-1:0] w_z0, w_z_rot, w_z_nxt;
    logic signed [c_XW-1:0]    w_mag, w_x0, w_y0;
    logic signed [c_XW-1:0]    w_xs, w_ys, w_x_rot, w_y_rot, w_x_nxt, w_y_nxt;
    logic signed [c_XW-1:0]    w_y_q, w_im_r;
    logic [DATA_WIDTH-1:0]     w_re_q, w_im_q;
    logic                      w_busy_nxt, w_done_nxt, w_wr_en_nxt;
    logic [c_KW-1:0]           w_wr_addr_nxt;
    logic [2*DATA_WIDTH-1:0]   w_wr_data_nxt;

    assign w_accept    = ((r_state == S_IDLE) || (r_state == S_FINISH)) && start;
    assign w_last_k    = &r_k;
    assign w_last_iter = (r_iter == c_IW'(ITER - 1));

    // Start vector: theta = -2*pi*k/N; upper half of the table is pre-rotated
    // by -pi/2 so the residual angle stays in (-pi/2, 0].
    assign w_k_ext = {{(ANGLE_W - c_KW){1'b0}}, r_k};
    assign w_theta = -(w_k_ext << (ANGLE_W - c_AW));
    assign w_z0    = r_k[c_KW-1] ? w_theta + c_QUARTER : w_theta;
    // On-axis entries skip the micro-rotations and load the exact amplitude.
    assign w_axis  = (w_z0 == '0);
    assign w_mag   = w_axis ? c_A4X : c_KA4X;
    assign w_x0    = r_k[c_KW-1] ? '0 : w_mag;
    assign w_y0    = r_k[c_KW-1] ? -w_mag : '0;

    // One CORDIC micro-rotation; z >= 0 rotates counter-clockwise.
    assign w_xs = r_x >>> r_iter;
    assign w_ys = r_y >>> r_iter;
    always_comb begin
        if (!r_z[ANGLE_W-1]) begin
            w_x_rot = r_x - w_ys;
            w_y_rot = r_y + w_xs;
            w_z_rot = r_z - w_atan[r_iter];
        end else begin
            w_x_rot = r_x + w_ys;
            w_y_rot = r_y - w_xs;
            w_z_rot = r_z + w_atan[r_iter];
        end
    end

    assign w_x_nxt = r_hold ? r_x : w_x_rot;
    assign w_y_nxt = r_hold ? r_y : w_y_rot;
    assign w_z_nxt = r_hold ? r_z : w_z_rot;

    // Output quantisation of the vector produced by the final micro-rotation.
    assign w_re_q = f_sat(f_round(w_x_nxt));
    assign w_y_q  = f_round(w_y_nxt);
`ifdef TWIDDLE_GEN_CONJ_EN
    assign w_im_r = -w_y_q;
`else
    assign w_im_r = w_y_q;
`endif
    assign w_im_q = f_sat(w_im_r);

    // State register together with the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            busy    <= w_busy_nxt;
            done    <= w_done_nxt;
            wr_en   <= w_wr_en_nxt;
            wr_addr <= w_wr_addr_nxt;
            wr_data <= w_wr_data_nxt;
        end
    end

    // Next-state sequencing: INIT, ITER rotations, WRITE per table entry.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_INIT;
            S_INIT:   w_state_nxt = S_ROTATE;
            S_ROTATE: if (w_last_iter) w_state_nxt = S_WRITE;
            S_WRITE:  w_state_nxt = w_last_k ? S_FINISH : S_INIT;
            S_FINISH: if (start) w_state_nxt = S_INIT;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state; write data holds between strobes.
    always_comb begin
        w_busy_nxt    = (w_state_nxt == S_INIT) || (w_state_nxt == S_ROTATE) ||
                        (w_state_nxt == S_WRITE);
        w_done_nxt    = (w_state_nxt == S_FINISH);
        w_wr_en_nxt   = (w_state_nxt == S_WRITE);
        w_wr_addr_nxt = wr_addr;
        w_wr_data_nxt = wr_data;
        if (w_state_nxt == S_WRITE) begin
            w_wr_addr_nxt = r_k;
            w_wr_data_nxt = {w_re_q, w_im_q};
        end
    end

    // CORDIC datapath, entry index and iteration counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k    <= '0;
            r_iter <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_hold <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_FINISH: begin
                    if (w_accept) r_k <= '0;
                end
                S_INIT: begin
                    r_x    <= w_x0;
                    r_y    <= w_y0;
                    r_z    <= w_z0;
                    r_hold <= w_axis;
                    r_iter <= '0;
                end
                S_ROTATE: begin
                    r_x    <= w_x_nxt;
                    r_y    <= w_y_nxt;
                    r_z    <= w_z_nxt;
                    r_iter <= r_iter + c_IW'(1);
                end
                S_WRITE: begin
                    if (!w_last_k) r_k <= r_k + c_KW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_twiddle_gen_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_twiddle_gen_loader                                         |
// | Purpose  : Self-checking bench: N=16 and N=64 generators against a       |
// |            cos/sin reference and a cycle-schedule model of the run.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_twiddle_gen_loader;

    localparam int c_ITER = 14;
    localparam int c_P    = c_ITER + 2;
    localparam int c_AMP  = 2047;
    localparam int c_NA   = 16;
    localparam int c_NB   = 64;
`ifdef TWIDDLE_GEN_CONJ_EN
    localparam int c_ISGN = 1;
`else
    localparam int c_ISGN = -1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, start_a, start_b;
    logic        busy_a, done_a, wr_en_a;
    logic        busy_b, done_b, wr_en_b;
    logic [2:0]  wr_addr_a;
    logic [4:0]  wr_addr_b;
    logic [23:0] wr_data_a, wr_data_b;

    twiddle_gen_loader #(.OFDM_WIDTH(c_NA), .DATA_WIDTH(12), .ITER(c_ITER), .ANGLE_W(16)) u_dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a));

    twiddle_gen_loader #(.OFDM_WIDTH(c_NB), .DATA_WIDTH(12), .ITER(c_ITER), .ANGLE_W(16)) u_dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int s_start [2];
    bit s_valid [2];
    int s_last  [2];

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int model_re(input int n, input int k);
        return rnd($itor(c_AMP) * $cos(6.283185307179586 * $itor(k) / $itor(n)));
    endfunction

    function automatic int model_im(input int n, input int k);
        return c_ISGN * rnd($itor(c_AMP) * $sin(6.283185307179586 * $itor(k) / $itor(n)));
    endfunction

    function automatic int tol(input int n, input int k);
        if (k == 0)     return 0;
        if (k == n / 4) return 1;
        return 2;
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d want %0d", name, cyc, act, exp);
        end
    endtask

    // Compare one generator against the schedule model and the cos/sin reference.
    task automatic chk_inst(input int id, input int n, input bit in_rst, input logic busy,
                            input logic done, input logic we, input int addr, input logic [23:0] data);
        int re, im, ek, t, len;
        bit eb, ed, ew;
        string tag;
        tag = (id == 0) ? "a" : "b";
        re  = int'($signed(data[23:12]));
        im  = int'($signed(data[11:0]));
        len = (n / 2) * c_P;
        if (in_rst) begin
            chk(busy == 1'b0, {tag, "_rst_busy"}, int'(busy), 0);
            chk(done == 1'b0, {tag, "_rst_done"}, int'(done), 0);
            chk(we == 1'b0,   {tag, "_rst_wr_en"}, int'(we), 0);
            chk(addr == 0,    {tag, "_rst_addr"}, addr, 0);
            chk(data == 24'd0, {tag, "_rst_data"}, int'(data), 0);
            s_last[id] = -1;
            return;
        end
        eb = 1'b0; ed = 1'b0; ew = 1'b0;
        ek = s_last[id];
        if (s_valid[id]) begin
            t  = cyc - s_start[id];
            eb = (t <= len - 1);
            ed = (t >= len);
            ew = (t < len) && ((t % c_P) == c_P - 1);
            if (ew) ek = t / c_P;
        end
        chk(busy == eb, {tag, "_busy"}, int'(busy), int'(eb));
        chk(done == ed, {tag, "_done"}, int'(done), int'(ed));
        chk(we == ew,   {tag, "_wr_en"}, int'(we), int'(ew));
        if (ek < 0) begin
            chk(addr == 0, {tag, "_idle_addr"}, addr, 0);
            chk(data == 24'd0, {tag, "_idle_data"}, int'(data), 0);
        end else begin
            chk(addr == ek, {tag, "_addr"}, addr, ek);
            chk(iabs(re - model_re(n, ek)) <= tol(n, ek), $sformatf("%s_re_k%0d", tag, ek), re, model_re(n, ek));
            chk(iabs(im - model_im(n, ek)) <= tol(n, ek), $sformatf("%s_im_k%0d", tag, ek), im, model_im(n, ek));
        end
        if (ew) begin
            s_last[id] = ek;
            if (id == 0) begin
                case (ek)
                    0: begin
                        chk(re == 2047, "lit_k0_re", re, 2047);
                        chk(im == 0,    "lit_k0_im", im, 0);
                    end
                    2: begin
                        chk(iabs(re - 1447) <= 2, "lit_k2_re", re, 1447);
                        chk(iabs(im - c_ISGN * 1447) <= 2, "lit_k2_im", im, c_ISGN * 1447);
                    end
                    4: begin
                        chk(iabs(re) <= 1, "lit_k4_re", re, 0);
                        chk(iabs(im - c_ISGN * 2047) <= 1, "lit_k4_im", im, c_ISGN * 2047);
                    end
                    6: begin
                        chk(iabs(re + 1447) <= 2, "lit_k6_re", re, -1447);
                        chk(iabs(im - c_ISGN * 1447) <= 2, "lit_k6_im", im, c_ISGN * 1447);
                    end
                    default: ;
                endcase
            end
        end
    endtask

    // Reference run bookkeeping: a start is accepted only when no run is in
    // flight or the previous run has completed.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_a) s_valid[0] = 1'b0;
        else if (start_a && (!s_valid[0] || (cyc - 1 - s_start[0]) >= (c_NA / 2) * c_P)) begin
            s_valid[0] = 1'b1;
            s_start[0] = cyc;
        end
        if (rst_b) s_valid[1] = 1'b0;
        else if (start_b && (!s_valid[1] || (cyc - 1 - s_start[1]) >= (c_NB / 2) * c_P)) begin
            s_valid[1] = 1'b1;
            s_start[1] = cyc;
        end
    end

    // Output comparison away from the active edge.
    always @(negedge clk) begin
        chk_inst(0, c_NA, rst_a, busy_a, done_a, wr_en_a, int'(wr_addr_a), wr_data_a);
        chk_inst(1, c_NB, rst_b, busy_b, done_b, wr_en_b, int'(wr_addr_b), wr_data_b);
    end

    task automatic pulse_a();
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
    endtask

    initial begin
        s_valid[0] = 1'b0; s_valid[1] = 1'b0;
        s_start[0] = 0;    s_start[1] = 0;
        s_last[0]  = -1;   s_last[1]  = -1;
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b0; rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1 start_a = 1'b1; start_b = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0; start_b = 1'b0;
        // starts during busy, after addr 2 and after addr 5
        repeat (49) @(posedge clk);
        #1 pulse_a();
        repeat (45) @(posedge clk);
        #1 pulse_a();
        // start while done
        repeat (40) @(posedge clk);
        #1 pulse_a();
        // asynchronous reset in the middle of rotating entry 3
        repeat (52) @(posedge clk);
        #3 rst_a = 1'b1;
        #1;
        chk(busy_a == 1'b0,     "async_rst_busy", int'(busy_a), 0);
        chk(done_a == 1'b0,     "async_rst_done", int'(done_a), 0);
        chk(wr_en_a == 1'b0,    "async_rst_wr_en", int'(wr_en_a), 0);
        chk(wr_addr_a == 3'd0,  "async_rst_addr", int'(wr_addr_a), 0);
        chk(wr_data_a == 24'd0, "async_rst_data", int'(wr_data_a), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_a = 1'b0;
        repeat (3) @(posedge clk);
        #1 pulse_a();
        repeat (140) @(posedge clk);
        // randomized start pulses and occasional resets
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            start_a = ($urandom_range(0, 49) == 0);
            start_b = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_a = 1'b1;
                @(posedge clk);
                #1 rst_a = 1'b0;
            end
        end
        @(posedge clk);
        #1 start_a = 1'b0; start_b = 1'b0;
        repeat (600) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
